control_sequencer: RTL and testbench

Hardwired control unit for the 32-bit bus-based datapath. Sequences one instruction per run: fetch (T0–T2), then register-to-register ALU execution (T3–T6). Drives the datapath's enable, select and ALU-op inputs directly. Replaces the hand-written control steps currently driven by benches. Decodes the instruction from the datapath's IR value.

---
 rtl/control_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_control_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetches one instruction (T0-T2) and sequences its
// register-to-register ALU execution (T3-T6), driving datapath controls directly.
module control_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [31:0] IR,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        HIin,
    output logic        LOin,
    output logic [15:0] R_in,
    output logic [15:0] R_out,
    output logic [12:0] alu_op,
    output logic [3:0]  state,
    output logic        done,
    output logic        illegal
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_T6    = 4'd7,
        S_FAULT = 4'd8
    } state_t;

    state_t state_q, state_d;

    logic [4:0]  opcode;
    logic [3:0]  ra, rb, rc;
    logic        cls_r3, cls_hl, cls_r2, legal;
    logic [12:0] op_sel;

    assign opcode = IR[31:27];
    assign ra     = IR[26:23];
    assign rb     = IR[22:19];
    assign rc     = IR[18:15];

    // Instruction class and one-hot ALU select; bit order NOT..AND = [12:0].
    always_comb begin
        cls_r3 = 1'b0;
        cls_hl = 1'b0;
        cls_r2 = 1'b0;
        op_sel = 13'd0;
        case (opcode)
            5'd3:  begin cls_r3 = 1'b1; op_sel[2]  = 1'b1; end
            5'd4:  begin cls_r3 = 1'b1; op_sel[3]  = 1'b1; end
            5'd5:  begin cls_r3 = 1'b1; op_sel[0]  = 1'b1; end
            5'd6:  begin cls_r3 = 1'b1; op_sel[1]  = 1'b1; end
            5'd7:  begin cls_r3 = 1'b1; op_sel[9]  = 1'b1; end
            5'd8:  begin cls_r3 = 1'b1; op_sel[10] = 1'b1; end
            5'd9:  begin cls_r3 = 1'b1; op_sel[6]  = 1'b1; end
            5'd10: begin cls_r3 = 1'b1; op_sel[7]  = 1'b1; end
            5'd11: begin cls_r3 = 1'b1; op_sel[8]  = 1'b1; end
            5'd15: begin cls_hl = 1'b1; op_sel[5]  = 1'b1; end
            5'd16: begin cls_hl = 1'b1; op_sel[4]  = 1'b1; end
            5'd17: begin cls_r2 = 1'b1; op_sel[11] = 1'b1; end
            5'd18: begin cls_r2 = 1'b1; op_sel[12] = 1'b1; end
            default: ;
        endcase
    end

    assign legal = cls_r3 | cls_hl | cls_r2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        PCout    = 1'b0;
        PCin     = 1'b0;
        IncPC    = 1'b0;
        MARin    = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        Zhighout = 1'b0;
        Zlowout  = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        R_in     = 16'd0;
        R_out    = 16'd0;
        alu_op   = 13'd0;
        done     = 1'b0;
        illegal  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_T0;
            end
            S_T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                PCin    = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                Read    = 1'b1;
                MDRin   = 1'b1;
                state_d = S_T2;
            end
            S_T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = S_T3;
            end
            // IR is first valid here; an illegal opcode leaves T3 silent.
            S_T3: begin
                if (!legal) begin
                    state_d = S_FAULT;
                end else begin
                    R_out[rb] = 1'b1;
                    state_d   = S_T4;
                    if (cls_r2) begin
                        alu_op = op_sel;
                        Zin    = 1'b1;
                    end else begin
                        Yin = 1'b1;
                    end
                end
            end
            S_T4: begin
                if (cls_r2) begin
                    Zlowout  = 1'b1;
                    R_in[ra] = 1'b1;
                    done     = 1'b1;
                    state_d  = run ? S_T0 : S_IDLE;
                end else begin
                    R_out[rc] = 1'b1;
                    alu_op    = op_sel;
                    Zin       = 1'b1;
                    state_d   = S_T5;
                end
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (cls_hl) begin
                    LOin    = 1'b1;
                    state_d = S_T6;
                end else begin
                    R_in[ra] = 1'b1;
                    done     = 1'b1;
                    state_d  = run ? S_T0 : S_IDLE;
                end
            end
            S_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                done     = 1'b1;
                state_d  = run ? S_T0 : S_IDLE;
            end
            S_FAULT: begin
                illegal = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: checks the full output bundle each
// cycle against hand-computed step tables.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [31:0] IR;
    logic        PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin;
    logic        Yin, Zin, Zhighout, Zlowout, HIin, LOin;
    logic [15:0] R_in, R_out;
    logic [12:0] alu_op;
    logic [3:0]  state;
    logic        done, illegal;

    int vectors = 0;
    int miscompares = 0;

    control_sequencer dut (
        .clk(clk), .reset(reset), .run(run), .IR(IR),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
        .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
        .Yin(Yin), .Zin(Zin), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .HIin(HIin), .LOin(LOin), .R_in(R_in), .R_out(R_out),
        .alu_op(alu_op), .state(state), .done(done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Bundle order: state[64:61], ctl[60:45], R_in[44:29], R_out[28:13], alu_op[12:0]
    logic [15:0] ctl;
    logic [64:0] obs;
    assign ctl = {PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
                  Yin, Zin, Zhighout, Zlowout, HIin, LOin, done, illegal};
    assign obs = {state, ctl, R_in, R_out, alu_op};

    localparam logic [15:0] C_T0   = 16'hF000;
    localparam logic [15:0] C_T1   = 16'h0C00;
    localparam logic [15:0] C_T2   = 16'h0300;
    localparam logic [15:0] C_YIN  = 16'h0080;
    localparam logic [15:0] C_ZIN  = 16'h0040;
    localparam logic [15:0] C_ZHI  = 16'h0020;
    localparam logic [15:0] C_ZLO  = 16'h0010;
    localparam logic [15:0] C_HIIN = 16'h0008;
    localparam logic [15:0] C_LOIN = 16'h0004;
    localparam logic [15:0] C_DONE = 16'h0002;
    localparam logic [15:0] C_ILL  = 16'h0001;

    localparam logic [12:0] OP_NOT = 13'h1000;
    localparam logic [12:0] OP_SHL = 13'h0100;
    localparam logic [12:0] OP_MUL = 13'h0010;

    localparam logic [64:0] E_IDLE = 65'd0;
    localparam logic [64:0] E_T0   = {4'd1, C_T0, 16'd0, 16'd0, 13'd0};
    localparam logic [64:0] E_T1   = {4'd2, C_T1, 16'd0, 16'd0, 13'd0};
    localparam logic [64:0] E_T2   = {4'd3, C_T2, 16'd0, 16'd0, 13'd0};

    localparam logic [64:0] SHL_T3 = {4'd4, C_YIN, 16'd0, 16'h0008, 13'd0};
    localparam logic [64:0] SHL_T4 = {4'd5, C_ZIN, 16'd0, 16'h0080, OP_SHL};
    localparam logic [64:0] SHL_T5 = {4'd6, C_ZLO | C_DONE, 16'h0010, 16'd0, 13'd0};

    task automatic test_reset();
        reset = 1'b0;
        run   = 1'b0;
        IR    = 32'd0;
        #2;
        vectors++;
        if (obs !== E_IDLE) begin
            miscompares++;
            $display("FAIL reset_asserted: got %h want %h", obs, E_IDLE);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (obs !== E_IDLE) begin
                miscompares++;
                $display("FAIL reset_release_idle[%0d]: got %h want %h", i, obs, E_IDLE);
            end
        end
    endtask

    task automatic test_shl();
        logic [64:0] seq [7];
        seq = '{E_T0, E_T1, E_T2, SHL_T3, SHL_T4, SHL_T5, E_IDLE};
        IR  = 32'h5A1B8000;
        run = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            run = 1'b0;
            vectors++;
            if (obs !== seq[i]) begin
                miscompares++;
                $display("FAIL shl_step[%0d]: got %h want %h", i, obs, seq[i]);
            end
        end
    endtask

    task automatic test_mul();
        logic [64:0] seq [8];
        seq = '{E_T0, E_T1, E_T2,
                {4'd4, C_YIN, 16'd0, 16'h0008, 13'd0},
                {4'd5, C_ZIN, 16'd0, 16'h0002, OP_MUL},
                {4'd6, C_ZLO | C_LOIN, 16'd0, 16'd0, 13'd0},
                {4'd7, C_ZHI | C_HIIN | C_DONE, 16'd0, 16'd0, 13'd0},
                E_IDLE};
        IR  = 32'h80188000;
        run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            run = 1'b0;
            vectors++;
            if (obs !== seq[i]) begin
                miscompares++;
                $display("FAIL mul_step[%0d]: got %h want %h", i, obs, seq[i]);
            end
        end
    endtask

    task automatic test_not();
        logic [64:0] seq [6];
        seq = '{E_T0, E_T1, E_T2,
                {4'd4, C_ZIN, 16'd0, 16'h0004, OP_NOT},
                {4'd5, C_ZLO | C_DONE, 16'h0020, 16'd0, 13'd0},
                E_IDLE};
        IR  = 32'h92900000;
        run = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            run = 1'b0;
            vectors++;
            if (obs !== seq[i]) begin
                miscompares++;
                $display("FAIL not_step[%0d]: got %h want %h", i, obs, seq[i]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [64:0] seq [4];
        logic [64:0] e_fault;
        seq     = '{E_T0, E_T1, E_T2, {4'd4, 16'd0, 16'd0, 16'd0, 13'd0}};
        e_fault = {4'd8, C_ILL, 16'd0, 16'd0, 13'd0};
        IR  = 32'h00000000;
        run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (obs !== seq[i]) begin
                miscompares++;
                $display("FAIL illegal_step[%0d]: got %h want %h", i, obs, seq[i]);
            end
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            run = i[0];
            vectors++;
            if (obs !== e_fault) begin
                miscompares++;
                $display("FAIL fault_hold[%0d]: got %h want %h", i, obs, e_fault);
            end
        end
        run   = 1'b0;
        reset = 1'b0;
        #1;
        vectors++;
        if (obs !== E_IDLE) begin
            miscompares++;
            $display("FAIL fault_reset: got %h want %h", obs, E_IDLE);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (obs !== E_IDLE) begin
            miscompares++;
            $display("FAIL fault_release_idle: got %h want %h", obs, E_IDLE);
        end
    endtask

    task automatic test_back_to_back();
        logic [64:0] seq [11];
        seq = '{E_T0, E_T1, E_T2, SHL_T3, SHL_T4, SHL_T5,
                E_T0, E_T1, E_T2, SHL_T3, SHL_T4};
        IR  = 32'h5A1B8000;
        run = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            vectors++;
            if (obs !== seq[i]) begin
                miscompares++;
                $display("FAIL b2b_step[%0d]: got %h want %h", i, obs, seq[i]);
            end
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (obs !== E_IDLE) begin
            miscompares++;
            $display("FAIL b2b_reset_mid_t4: got %h want %h", obs, E_IDLE);
        end
        @(negedge clk);
        vectors++;
        if (obs !== E_IDLE) begin
            miscompares++;
            $display("FAIL b2b_reset_held: got %h want %h", obs, E_IDLE);
        end
        reset = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i == 5) run = 1'b0;
            vectors++;
            if (obs !== seq[i] && i < 6) begin
                miscompares++;
                $display("FAIL b2b_restart[%0d]: got %h want %h", i, obs, seq[i]);
            end else if (i == 6 && obs !== E_IDLE) begin
                miscompares++;
                $display("FAIL b2b_final_idle: got %h want %h", obs, E_IDLE);
            end
        end
    endtask

    initial begin
        test_reset();
        test_shl();
        test_mul();
        test_not();
        test_illegal();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
